// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that assembles WORD_BYTES consecutive bytes into a 32-bit word.
// State | meaning: IDLE wait for start edge | START confirm start at mid-bit | DATA shift 8 bits | STOP check stop bit | CLEANUP one-cycle gap
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 87,
    parameter int WORD_BYTES   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        serial_in,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_frame_err,
    output logic        o_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [1:0]  LAST_IDX = 2'(WORD_BYTES - 1);

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_rx_prev;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_shadow;
    logic [7:0]  r_byte;
    logic        r_byte_valid;
    logic [31:0] r_word;
    logic        r_word_valid;
    logic        r_frame_err;
    logic        r_active;

    logic        w_rx;
    logic        w_fall;
    logic [31:0] w_shadow_next;

    assign w_rx   = r_sync2;
    assign w_fall = r_rx_prev & ~w_rx;

    // Lanes at or above WORD_BYTES are never written, so they stay zero.
    always_comb begin
        w_shadow_next = r_shadow;
        for (int lane = 0; lane < 4; lane++) begin
            if (lane < WORD_BYTES && r_byte_idx == 2'(lane)) begin
                w_shadow_next[8*lane +: 8] = r_shift;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= serial_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_idx   <= '0;
            r_shadow     <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (enable && w_fall) begin
                        r_state   <= S_START;
                        r_cnt     <= HALF_BIT;
                        r_bit_idx <= '0;
                        r_active  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (w_rx) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end else begin
                        r_state   <= S_DATA;
                        r_cnt     <= BIT_LAST;
                        r_bit_idx <= '0;
                    end
                end

                S_DATA: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_cnt   <= BIT_LAST;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

                S_STOP: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_state <= S_CLEANUP;
                        r_cnt   <= '0;
                        if (w_rx) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                            r_shadow     <= w_shadow_next;
                            if (r_byte_idx == LAST_IDX) begin
                                r_word       <= w_shadow_next;
                                r_word_valid <= 1'b1;
                                r_byte_idx   <= '0;
                            end else begin
                                r_byte_idx <= r_byte_idx + 2'd1;
                            end
                        end else begin
                            // A broken frame also breaks word alignment.
                            r_frame_err <= 1'b1;
                            r_byte_idx  <= '0;
                        end
                    end
                end

                S_CLEANUP: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_frame_err  = r_frame_err;
    assign o_active     = r_active;

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: a 4-byte receiver at 87 clocks/bit and a 2-byte receiver at 4 clocks/bit.
`timescale 1ns/1ps
module tb_uart_rx_word;

    localparam int CLK_A = 87;
    localparam int CLK_B = 4;

    logic        clock;
    logic        reset_n;
    logic        en_a, rx_a, rx_b;
    logic [7:0]  a_byte, b_byte;
    logic [31:0] a_word, b_word;
    logic        a_bv, a_wv, a_err, a_active;
    logic        b_bv, b_wv, b_err, b_active;

    int checks = 0;
    int errors = 0;

    logic [7:0]  byte_q[$];
    logic [31:0] word_q[$];
    bit          coinc_q[$];
    int          err_cnt;
    int          active_cycles;
    logic [7:0]  b_byte_q[$];
    logic [31:0] b_word_q[$];
    int          b_err_cnt;

    uart_rx_word #(.CLKS_PER_BIT(CLK_A), .WORD_BYTES(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(en_a), .serial_in(rx_a),
        .o_byte(a_byte), .o_byte_valid(a_bv), .o_word(a_word), .o_word_valid(a_wv),
        .o_frame_err(a_err), .o_active(a_active)
    );

    uart_rx_word #(.CLKS_PER_BIT(CLK_B), .WORD_BYTES(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(1'b1), .serial_in(rx_b),
        .o_byte(b_byte), .o_byte_valid(b_bv), .o_word(b_word), .o_word_valid(b_wv),
        .o_frame_err(b_err), .o_active(b_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (a_bv) byte_q.push_back(a_byte);
        if (a_wv) begin
            word_q.push_back(a_word);
            coinc_q.push_back(a_bv);
        end
        if (a_err) err_cnt++;
        if (a_active) active_cycles++;
        if (b_bv) b_byte_q.push_back(b_byte);
        if (b_wv) b_word_q.push_back(b_word);
        if (b_err) b_err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        byte_q.delete();
        word_q.delete();
        coinc_q.delete();
        err_cnt = 0;
        active_cycles = 0;
        b_byte_q.delete();
        b_word_q.delete();
        b_err_cnt = 0;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        clear_mon();
    endtask

    task automatic drive_bit(input int which, input logic v, input int n);
        if (which == 0) rx_a = v;
        else rx_b = v;
        repeat (n) @(negedge clock);
    endtask

    // Whole 8N1 frame; a bad stop bit is followed by two bit times of idle so the next start is visible.
    task automatic send_frame(input int which, input logic [7:0] b, input bit stop_ok);
        int n;
        n = (which == 0) ? CLK_A : CLK_B;
        drive_bit(which, 1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(which, b[i], n);
        drive_bit(which, stop_ok, n);
        if (!stop_ok) drive_bit(which, 1'b1, 2 * n);
        if (which == 0) rx_a = 1'b1;
        else rx_b = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (a_byte !== 8'h00 || a_word !== 32'h0 || a_bv !== 1'b0 || a_wv !== 1'b0 ||
            a_err !== 1'b0 || a_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: byte=%h word=%h bv=%b wv=%b err=%b act=%b, required all 0",
                     a_byte, a_word, a_bv, a_wv, a_err, a_active);
        end
        checks++;
        if (b_byte !== 8'h00 || b_word !== 32'h0 || b_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: byte=%h word=%h act=%b, required all 0", b_byte, b_word, b_active);
        end
        reset_dut();
        repeat (10) @(negedge clock);
        checks++;
        if (byte_q.size() != 0 || word_q.size() != 0 || err_cnt != 0 || active_cycles != 0) begin
            errors++;
            $display("FAIL reset_idle: bytes=%0d words=%0d errs=%0d active=%0d, required 0",
                     byte_q.size(), word_q.size(), err_cnt, active_cycles);
        end
    endtask

    task automatic test_single();
        reset_dut();
        send_frame(0, 8'hA5, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (byte_q.size() != 1 || byte_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_byte: count=%0d first=%h, required 1 x a5",
                     byte_q.size(), (byte_q.size() > 0) ? byte_q[0] : 8'hxx);
        end
        checks++;
        if (a_byte !== 8'hA5) begin
            errors++;
            $display("FAIL single_obyte: got %h required a5", a_byte);
        end
        checks++;
        if (word_q.size() != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL single_nopulse: words=%0d errs=%0d required 0", word_q.size(), err_cnt);
        end
        checks++;
        if (active_cycles < 9 * CLK_A || active_cycles > 10 * CLK_A || a_active !== 1'b0) begin
            errors++;
            $display("FAIL single_active: cycles=%0d now=%b required %0d..%0d and now 0",
                     active_cycles, a_active, 9 * CLK_A, 10 * CLK_A);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[4];
        exp = '{8'h9B, 8'hF3, 8'h1A, 8'h04};
        reset_dut();
        for (int i = 0; i < 4; i++) send_frame(0, exp[i], 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (byte_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes required 4", byte_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (byte_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h required %h", i, byte_q[i], exp[i]);
                end
            end
        end
        checks++;
        if (word_q.size() != 1 || word_q[0] !== 32'h041AF39B || coinc_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_word: count=%0d word=%h coincident=%b required 1 x 041af39b with byte pulse",
                     word_q.size(), (word_q.size() > 0) ? word_q[0] : 32'hx,
                     (coinc_q.size() > 0) ? coinc_q[0] : 1'b0);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] exp[5];
        exp = '{8'h77, 8'h11, 8'h22, 8'h33, 8'h44};
        reset_dut();
        send_frame(0, 8'h77, 1'b1);
        send_frame(0, 8'h3C, 1'b0);
        for (int i = 1; i < 5; i++) send_frame(0, exp[i], 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (err_cnt != 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d error pulses required 1", err_cnt);
        end
        checks++;
        if (byte_q.size() != 5) begin
            errors++;
            $display("FAIL ferr_bytes: got %0d bytes required 5", byte_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (byte_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL ferr_byte%0d: got %h required %h", i, byte_q[i], exp[i]);
                end
            end
        end
        checks++;
        if (word_q.size() != 1 || a_word !== 32'h44332211) begin
            errors++;
            $display("FAIL ferr_word: count=%0d word=%h required 1 x 44332211", word_q.size(), a_word);
        end
    endtask

    task automatic test_glitch();
        reset_dut();
        rx_a = 1'b0;
        repeat (10) @(negedge clock);
        rx_a = 1'b1;
        repeat (200) @(negedge clock);
        checks++;
        if (byte_q.size() != 0 || word_q.size() != 0 || err_cnt != 0 || a_active !== 1'b0) begin
            errors++;
            $display("FAIL glitch: bytes=%0d words=%0d errs=%0d active=%b required none",
                     byte_q.size(), word_q.size(), err_cnt, a_active);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] part;
        part = 8'hC3;
        reset_dut();
        send_frame(0, 8'h33, 1'b1);
        repeat (5) @(negedge clock);
        drive_bit(0, 1'b0, CLK_A);
        for (int i = 0; i < 4; i++) drive_bit(0, part[i], CLK_A);
        drive_bit(0, part[4], 40);
        checks++;
        if (a_active !== 1'b1 || a_byte !== 8'h33) begin
            errors++;
            $display("FAIL rmid_pre: active=%b byte=%h required 1 and 33", a_active, a_byte);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (a_byte !== 8'h00 || a_word !== 32'h0 || a_active !== 1'b0 || a_bv !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL rmid_clear: byte=%h word=%h act=%b bv=%b err=%b required 0",
                     a_byte, a_word, a_active, a_bv, a_err);
        end
        repeat (5) @(negedge clock);
        rx_a = 1'b1;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        clear_mon();
        repeat (5) @(negedge clock);
        send_frame(0, 8'h5A, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (byte_q.size() != 1 || a_byte !== 8'h5A || err_cnt != 0) begin
            errors++;
            $display("FAIL rmid_next: count=%0d byte=%h errs=%0d required 1 x 5a", byte_q.size(), a_byte, err_cnt);
        end
    endtask

    task automatic test_enable();
        reset_dut();
        send_frame(0, 8'h01, 1'b1);
        send_frame(0, 8'h02, 1'b1);
        fork
            send_frame(0, 8'h03, 1'b1);
            begin
                repeat (300) @(negedge clock);
                en_a = 1'b0;
            end
        join
        send_frame(0, 8'h04, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (byte_q.size() != 3 || a_byte !== 8'h03 || a_active !== 1'b0) begin
            errors++;
            $display("FAIL enable_off: count=%0d byte=%h active=%b required 3 bytes, last 03, idle",
                     byte_q.size(), a_byte, a_active);
        end
        en_a = 1'b1;
        repeat (5) @(negedge clock);
        send_frame(0, 8'h05, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (word_q.size() != 1 || a_word !== 32'h05030201) begin
            errors++;
            $display("FAIL enable_word: count=%0d word=%h required 1 x 05030201", word_q.size(), a_word);
        end
    endtask

    task automatic test_random();
        logic [7:0]  b;
        bit          ok;
        int          gap;
        int          idx;
        int          exp_err;
        logic [31:0] acc;
        logic [7:0]  exp_b[$];
        logic [31:0] exp_w[$];
        reset_dut();
        idx = 0;
        exp_err = 0;
        acc = '0;
        for (int n = 0; n < 12; n++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 4) != 0);
            gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40);
            if (ok) begin
                exp_b.push_back(b);
                acc[8*idx +: 8] = b;
                idx++;
                if (idx == 4) begin
                    exp_w.push_back(acc);
                    idx = 0;
                end
            end else begin
                exp_err++;
                idx = 0;
            end
            send_frame(0, b, ok);
            repeat (gap) @(negedge clock);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (byte_q.size() != exp_b.size() || word_q.size() != exp_w.size() || err_cnt != exp_err) begin
            errors++;
            $display("FAIL rand_counts: bytes=%0d/%0d words=%0d/%0d errs=%0d/%0d (got/required)",
                     byte_q.size(), exp_b.size(), word_q.size(), exp_w.size(), err_cnt, exp_err);
        end else begin
            for (int i = 0; i < exp_b.size(); i++) begin
                checks++;
                if (byte_q[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL rand_byte%0d: got %h required %h", i, byte_q[i], exp_b[i]);
                end
            end
            for (int i = 0; i < exp_w.size(); i++) begin
                checks++;
                if (word_q[i] !== exp_w[i] || coinc_q[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_word%0d: got %h coincident=%b required %h", i, word_q[i], coinc_q[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_word2();
        logic [7:0]  b;
        logic [7:0]  lo;
        logic [31:0] exp_w[$];
        reset_dut();
        send_frame(1, 8'hCD, 1'b1);
        send_frame(1, 8'hAB, 1'b1);
        repeat (10) @(negedge clock);
        checks++;
        if (b_byte_q.size() != 2 || b_word_q.size() != 1 || b_word !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL word2_basic: bytes=%0d words=%0d word=%h required 2, 1, 0000abcd",
                     b_byte_q.size(), b_word_q.size(), b_word);
        end
        clear_mon();
        lo = '0;
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom_range(0, 255));
            if (n % 2 == 0) lo = b;
            else exp_w.push_back({16'h0000, b, lo});
            send_frame(1, b, 1'b1);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 9)) @(negedge clock);
        end
        repeat (10) @(negedge clock);
        checks++;
        if (b_word_q.size() != exp_w.size() || b_err_cnt != 0) begin
            errors++;
            $display("FAIL word2_count: words=%0d errs=%0d required %0d and 0", b_word_q.size(), b_err_cnt, exp_w.size());
        end else begin
            for (int i = 0; i < exp_w.size(); i++) begin
                checks++;
                if (b_word_q[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL word2_rand%0d: got %h required %h", i, b_word_q[i], exp_w[i]);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        en_a    = 1'b1;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        clear_mon();
        repeat (2) @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_enable();
        test_random();
        test_word2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, SHALL set clock cycles per serial bit (legal range 4..65535).
REQ-002 Parameter WORD_BYTES, default 4, SHALL set bytes per assembled word (legal 1..4).
REQ-003 clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  SHALL be asynchronous, active-low reset.
REQ-005 enable  input  1  high = receiver runs; low = FSM held in IDLE, no new frames.
REQ-006 serial_in  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 o_byte  output  8  last received data byte.
REQ-008 o_byte_valid  output  1  one-cycle pulse when o_byte updates.
REQ-009 o_word  output  32  assembled word; first received byte in bits [7:0]; bits above WORD_BYTES*8 are 0.
REQ-010 o_word_valid  output  1  one-cycle pulse when o_word updates.
REQ-011 o_frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-012 o_active  output  1  high while FSM is not IDLE.

Function
REQ-013 serial_in SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, CLEANUP.
REQ-015 IDLE -> START on synchronized falling edge of the line (high then low) with enable=1; bit counter cleared.
REQ-016 START: at cycle (CLKS_PER_BIT-1)/2 of the start bit, line low -> DATA with counter cleared; line high -> IDLE (glitch rejected, no output, no error).
REQ-017 DATA: sample once per CLKS_PER_BIT cycles at bit midpoint, shift into byte LSB first; after 8th sample -> STOP.
REQ-018 STOP: sample at stop-bit midpoint; high -> byte accepted; low -> o_frame_err pulses, byte discarded, word assembly index cleared to 0; both cases -> CLEANUP.
REQ-019 CLEANUP: lasts exactly 1 cycle, then -> IDLE; back-to-back frames with no idle gap SHALL be received.
REQ-020 On byte accept, o_byte and o_byte_valid SHALL update in the same cycle as the stop-bit sample (registered, visible next edge).
REQ-021 Byte index (0..WORD_BYTES-1) SHALL place accepted byte at o_word lane [8*idx+7:8*idx] of a shadow register; o_word is loaded from shadow and o_word_valid pulses in the same cycle the last byte is accepted; index wraps to 0.
REQ-022 o_word SHALL hold its value between pulses; o_byte_valid and o_word_valid pulse together for the final byte.
REQ-023 enable deasserted mid-frame SHALL let the current frame finish; FSM then stays in IDLE; byte index is preserved.
REQ-024 Baud counter width SHALL be 16 bits; it never wraps within a bit period.

Reset
REQ-025 reset_n low SHALL asynchronously force: FSM IDLE, counters 0, byte index 0, shadow 0, o_byte=0x00, o_word=0x00000000, all pulses 0, o_active=0, synchronizer flops 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulses; first frame after release is received normally provided it starts after >=2 cycles of idle-high line.

Verification
REQ-027 Single frame 0xA5, CLKS_PER_BIT=87 -> o_byte=0xA5, one o_byte_valid pulse, o_word_valid stays 0, o_active high for frame duration.
REQ-028 Frames 0x9B,0xF3,0x1A,0x04 back-to-back -> four byte pulses, one o_word_valid with o_word=0x041AF39B coincident with the 4th byte pulse.
REQ-029 Frame 0x3C with stop bit forced low -> o_frame_err one pulse, no o_byte_valid, next 4 good bytes 0x11,0x22,0x33,0x44 -> o_word=0x44332211.
REQ-030 Low glitch of 10 cycles on idle line -> FSM returns to IDLE, no pulses of any output.
REQ-031 reset_n pulsed low during bit 4 of a frame -> all outputs 0 immediately; following frame 0x5A -> o_byte=0x5A.
REQ-032 WORD_BYTES=2, frames 0xCD,0xAB -> o_word=0x0000ABCD, one o_word_valid pulse.
